// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Optional feature macro used by the arbiter: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_AUX = 1'b1;

  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker for the memory bus arbiter.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin contention handling; otherwise m0 has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority never consults the previous winner.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    valid_o = |req_i;
    grant_o = MASTER_CPU;
    if (req_i[0] && req_i[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_o = ~last_grant_i;
`else
      grant_o = MASTER_CPU;
`endif
    end else if (req_i[1]) begin
      grant_o = MASTER_AUX;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of the memory controller: one transaction per slot, fixed strobe latency.
// Contention policy set by MEM_ARB_ROUND_ROBIN_EN (defined: alternate, undefined: m0 priority).
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_error,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_error,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_error
);

  arb_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 pick_grant;
  logic                 pick_valid;

  mem_arb_pick u_pick (
    .req_i        ({m1_req, m0_req}),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant),
    .valid_o      (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          we_d    = pick_grant ? m1_we    : m0_we;
          addr_d  = pick_grant ? m1_addr  : m0_addr;
          wdata_d = pick_grant ? m1_wdata : m0_wdata;
          cnt_d   = LAT_CNT_W'(MEM_LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          err_d   = mem_error;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset drops any in-flight transaction; it is never acked.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= MASTER_CPU;
      last_grant_q <= MASTER_AUX;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mem_read  = (state_q == ACCESS) && !we_q;
  assign mem_write = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign m0_ack   = (state_q == RESP) && (grant_q == MASTER_CPU);
  assign m1_ack   = (state_q == RESP) && (grant_q == MASTER_AUX);
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;
  assign m0_error = err_q & m0_ack;
  assign m1_error = err_q & m1_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: table-driven transactions, directed corner cases,
// and a randomized run against a cycle-numbered transaction model (honours MEM_ARB_ROUND_ROBIN_EN).
module tb_mem_bus_arbiter;

  localparam int L = 3;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_error, m1_ack, m1_error;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write, mem_error;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_error(m0_error),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_error(m1_error),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_error(mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int unsigned cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: a transaction started in cycle t0 strobes in t0+1..t0+L,
  // samples the controller at t0+L and acks in t0+L+1.
  bit          m_valid = 0, m_busy = 0, m_fresh = 0;
  bit          m_master, m_we, m_last, m_err;
  int unsigned m_t0;
  logic [31:0] m_addr, m_wdata, m_rdata;

  task automatic model_step();
    if (!rst) begin
      m_valid = 1; m_busy = 0; m_last = 1; m_err = 0;
      m_rdata = 0; m_addr = 0; m_wdata = 0; m_fresh = 1;
    end else if (m_valid) begin
      if (m_busy) begin
        if (cyc == m_t0 + L) begin
          m_rdata = mem_rdata;
          m_err   = mem_error;
        end
        if (cyc == m_t0 + L + 1) begin
          m_busy = 0;
          m_last = m_master;
        end
      end else if (m0_req || m1_req) begin
        if (m0_req && m1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          m_master = !m_last;
`else
          m_master = 0;
`endif
        end else begin
          m_master = m1_req;
        end
        m_we    = m_master ? m1_we    : m0_we;
        m_addr  = m_master ? m1_addr  : m0_addr;
        m_wdata = m_master ? m1_wdata : m0_wdata;
        m_t0    = cyc;
        m_busy  = 1;
        m_fresh = 0;
      end
    end
    cyc++;
  endtask

  task automatic model_check();
    bit stb, ack;
    if (!m_valid) return;
    stb = m_busy && (cyc >= m_t0 + 1) && (cyc <= m_t0 + L);
    ack = m_busy && (cyc == m_t0 + L + 1);
    chk("mdl_mem_read", mem_read, stb && !m_we);
    chk("mdl_mem_write", mem_write, stb && m_we);
    chk("mdl_m0_ack", m0_ack, ack && !m_master);
    chk("mdl_m1_ack", m1_ack, ack && m_master);
    chk("mdl_m0_error", m0_error, ack && !m_master && m_err);
    chk("mdl_m1_error", m1_error, ack && m_master && m_err);
    if (stb) begin
      chk("mdl_mem_addr", mem_addr, m_addr);
      if (m_we) chk("mdl_mem_wdata", mem_wdata, m_wdata);
    end
    if (ack) chk("mdl_rdata", m_master ? m1_rdata : m0_rdata, m_rdata);
    if (m_fresh) begin
      chk("mdl_reset_addr", mem_addr, 0);
      chk("mdl_reset_wdata", mem_wdata, 0);
      chk("mdl_reset_m0_rdata", m0_rdata, 0);
      chk("mdl_reset_m1_rdata", m1_rdata, 0);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    model_check();
  end

  typedef struct {
    bit          master;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    bit          merr;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic drive_master(input bit master, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata);
    m0_req = !master; m1_req = master;
    if (master) begin m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    else begin m0_we = we; m0_addr = addr; m0_wdata = wdata; end
  endtask

  task automatic run_tx(input vec_t v, input int idx);
    int nstb;
    bit got;
    @(posedge clk); #1;
    drive_master(v.master, v.we, v.addr, v.wdata);
    mem_rdata = v.mrdata;
    mem_error = v.merr;
    nstb = 0;
    got  = 0;
    for (int j = 0; j <= L + 4 && !got; j++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        nstb++;
        chk("tx_dir", mem_write, v.we);
        chk("tx_addr", mem_addr, v.addr);
        if (v.we) chk("tx_wdata", mem_wdata, v.wdata);
      end
      if (m0_ack || m1_ack) begin
        got = 1;
        chk("tx_ack_master", m1_ack, v.master);
        chk("tx_other_ack", v.master ? m0_ack : m1_ack, 0);
        chk("tx_latency", j, L + 1);
        if (!v.we) chk("tx_rdata", v.master ? m1_rdata : m0_rdata, v.exp_rdata);
        chk("tx_error", v.master ? m1_error : m0_error, v.exp_err);
      end
    end
    if (!got) chk("tx_ack_timeout", 0, 1);
    chk("tx_strobe_cycles", nstb, L);
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    $display("tx %0d: m%0d %s addr=%08h done", idx, v.master, v.we ? "write" : "read", v.addr);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 0; m0_req = 0; m1_req = 0;
    @(posedge clk); #1;
    rst = 1;
  endtask

  initial begin
    int n_ack;
    bit order[4];
    rst = 0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    mem_rdata = 0; mem_error = 0;

    vecs[0] = '{0, 0, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0};
    vecs[1] = '{1, 1, 32'h0000_2000, 32'h1234_5678,  32'h0,         1, 32'h0,         1};
    vecs[2] = '{1, 0, 32'hFFFF_FFFC, 32'h0,          32'h0000_0000, 0, 32'h0000_0000, 0};
    vecs[3] = '{0, 1, 32'h0000_0004, 32'hA5A5_A5A5,  32'h5555_5555, 0, 32'h0,         0};
    vecs[4] = '{0, 0, 32'h0000_0008, 32'h0,          32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1};
    vecs[5] = '{1, 0, 32'h0000_0010, 32'h0,          32'h1357_9BDF, 0, 32'h1357_9BDF, 0};

    repeat (2) @(posedge clk);
    #1 rst = 1;

    for (int i = 0; i < 6; i++) run_tx(vecs[i], i);

    // Reset while an m0 read is in ACCESS: no ack may follow.
    @(posedge clk); #1;
    drive_master(0, 0, 32'h0000_0300, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_read", mem_read, 1);
    rst = 0; m0_req = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rst_read", mem_read, 0);
    chk("rst_write", mem_write, 0);
    chk("rst_addr", mem_addr, 0);
    n_ack = 0;
    for (int j = 0; j < 8; j++) begin
      if (m0_ack || m1_ack) n_ack++;
      @(negedge clk);
    end
    chk("rst_no_ack", n_ack, 0);
    $display("tx rst: abandoned read not acked");
    run_tx(vecs[0], 6);

    // m0 drops req and moves its address while its read is in flight.
    @(posedge clk); #1;
    drive_master(0, 0, 32'h0000_0040, 32'h0);
    @(posedge clk); #1;
    m0_req = 0; m0_addr = 32'h0000_0080;
    n_ack = 0;
    for (int j = 0; j < L + 5; j++) begin
      @(negedge clk);
      if (mem_read) chk("mid_addr", mem_addr, 32'h0000_0040);
      if (m0_ack) n_ack++;
    end
    chk("mid_ack_once", n_ack, 1);
    $display("tx mid: m0 read addr=00000040 acked %0d time(s)", n_ack);

    // Continuous contention from a fresh reset.
    reset_dut();
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
    n_ack = 0;
    for (int j = 0; j < 4 * (L + 2) + 8 && n_ack < 4; j++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        order[n_ack] = m1_ack;
        n_ack++;
      end
    end
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    chk("cont_ack_count", n_ack, 4);
    for (int k = 0; k < 4 && k < n_ack; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("cont_order_rr", order[k], k % 2);
`else
      chk("cont_order_fixed", order[k], 0);
`endif
      $display("tx cont %0d: m%0d acked", k, order[k]);
    end

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 249) != 0);
      m0_req    = ($urandom_range(0, 2) != 0);
      m1_req    = ($urandom_range(0, 2) != 0);
      m0_we     = $urandom_range(0, 1) != 0;
      m1_we     = $urandom_range(0, 1) != 0;
      m0_addr   = $urandom;
      m1_addr   = $urandom;
      m0_wdata  = $urandom;
      m1_wdata  = $urandom;
      mem_rdata = $urandom;
      mem_error = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1;
    rst = 1; m0_req = 0; m1_req = 0;
    repeat (L + 4) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the single memory-controller port between the CPU core and a second bus master (DMA/debug loader) inside the MCU. Accepts at most one request per transaction slot, latches its address/data, drives the memory controller's read/write strobes for a fixed latency, and returns read data plus error status with a single-cycle acknowledge. It sits between the masters and `memory_controller`, and replaces the direct CPU-to-controller wiring.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LATENCY`, 1, cycles the strobe is held before data/error are sampled; legal range 1..15

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `m0_req` / `m1_req`  in  1  transaction request; level, held until ack
- `m0_we` / `m1_we`  in  1  1 = write, 0 = read
- `m0_addr` / `m1_addr`  in  ADDR_W  byte address
- `m0_wdata` / `m1_wdata`  in  DATA_W  write data
- `m0_ack` / `m1_ack`  out  1  one-cycle completion pulse
- `m0_rdata` / `m1_rdata`  out  DATA_W  read data, valid only in the ack cycle
- `m0_error` / `m1_error`  out  1  memory error, valid only in the ack cycle
- `mem_read` / `mem_write`  out  1  strobes to the memory controller
- `mem_addr`  out  ADDR_W  address to the controller
- `mem_wdata`  out  DATA_W  write data to the controller
- `mem_rdata`  in  DATA_W  read data from the controller
- `mem_error`  in  1  error from the controller

## Operation
- FSM states are IDLE, ACCESS and RESP.
- **IDLE**
  - If neither req is asserted, stay in IDLE.
  - Otherwise pick a master, then latch its `we`, `addr` and `wdata` into the working registers.
  - Record the grant, load `cnt = MEM_LATENCY-1` and go to ACCESS.
- **ACCESS**
  - `mem_read = ~we_q` and `mem_write = we_q`; `mem_addr` and `mem_wdata` come from the latched registers.
  - Decrement `cnt` each cycle.
  - When `cnt == 0`: capture `mem_rdata` and `mem_error` into `rdata_q`/`err_q`, then go to RESP.
- **RESP**
  - Strobes are low.
  - Pulse `ack` for the granted master only.
  - Update `last_grant` to the granted master, then go to IDLE.
- `m0_rdata` and `m1_rdata` are both driven from `rdata_q`. `mN_error = err_q & mN_ack`.
- Arbitration happens only in IDLE, so a grant is never preempted.
- If a master drops req during ACCESS, the transaction still completes and its ack is still pulsed.
- Inputs from the master are sampled only in the IDLE grant cycle. Later changes are ignored.
- A master that still holds req in the IDLE cycle after its ack starts a new transaction.
- Write errors are reported the same way as read errors.

## Timing
- Reset (`rst == 0` at the clock edge), including mid-transaction:
  - State goes to IDLE.
  - All strobes, acks and errors = 0; `rdata_q = 0`; `mem_addr`/`mem_wdata` = 0.
  - `last_grant = 1`, so m0 wins the first contention.
  - An abandoned transaction is never acked.
- Latency: req seen in IDLE at cycle T; strobe high in cycles T+1 .. T+MEM_LATENCY; ack in cycle T+MEM_LATENCY+1.
- Throughput: one transaction per MEM_LATENCY+2 cycles.
- Simultaneous req from both masters: the winner is set by the arbitration mode (see Configuration); the loser is served in the next slot.
- Strobes are never high outside ACCESS. `m0_ack` and `m1_ack` are never high together.

## Configuration
- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- **Defined:** on contention, grant the master that is not `last_grant`, so the two masters alternate under continuous load.
- **Undefined:** fixed priority, m0 always wins contention. m1 is served only when m0_req is low in IDLE, and starvation of m1 is permitted. `last_grant` is still maintained but has no effect on the decision.

## Structure
- Shared package `mem_arb_pkg` contains:
  - the state enum (IDLE/ACCESS/RESP);
  - master-id constants `MASTER_CPU = 0` and `MASTER_AUX = 1`;
  - the counter width `LAT_CNT_W = 4`.
- One sub-module, `mem_arb_pick`: a combinational grant picker taking the req vector and `last_grant` and returning the grant id plus a valid flag. It contains the macro-dependent logic.
- The top level contains the FSM, counter and datapath registers.

## Test plan
- **Reset mid-ACCESS:** MEM_LATENCY=3, m0 read in progress, assert rst low for one cycle. Expected: strobes are 0 on the next cycle, no ack ever, and the following m0 request is served normally.
- **Single read:** MEM_LATENCY=1, m0 read of addr 0x100, `mem_rdata = 0xDEADBEEF`. Expected: `mem_read` high for one cycle, then m0_ack=1 with m0_rdata=0xDEADBEEF and m0_error=0, two cycles after req is sampled.
- **Write with error:** MEM_LATENCY=2, m1 write to 0x2000 with data 0x12345678, `mem_error = 1`. Expected: `mem_write` high for two cycles with the correct addr/data, then m1_ack=1 and m1_error=1 with m0_ack=0.
- **Contention, round robin:** both masters request continuously for 4 slots with the macro defined. Expected: ack order m0, m1, m0, m1.
- **Contention, fixed priority:** same stimulus with the macro undefined. Expected: m0 acked on all 4 slots and m1 never acked.
- **Mid-transaction changes:** m0 drops req and changes m0_addr from 0x40 to 0x80 during ACCESS. Expected: `mem_addr` stays 0x40 and m0_ack still pulses once.
